// File: rtl/arp_arb_pkg.sv
// Shared definitions for the ARP lookup arbiter: FSM encoding and default timeout.
package arp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int ARB_DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/arp_lookup_arb_if.sv
// Lookup issue / result-FIFO link between the arbiter (master) and ip_arp (slave).
interface arp_lookup_arb_if #(
    parameter int NUM_QUEUES = 8
);
    logic                  lpm_vld;
    logic [31:0]           next_hop_ip;
    logic [NUM_QUEUES-1:0] lpm_output_port;
    logic                  lpm_hit;
    logic                  arp_mac_vld;
    logic [47:0]           next_hop_mac;
    logic [NUM_QUEUES-1:0] output_port;
    logic                  arp_lookup_hit;
    logic                  lpm_lookup_hit;
    logic                  rd_arp_result;

    modport master (
        output lpm_vld, next_hop_ip, lpm_output_port, lpm_hit, rd_arp_result,
        input  arp_mac_vld, next_hop_mac, output_port, arp_lookup_hit, lpm_lookup_hit
    );

    modport slave (
        input  lpm_vld, next_hop_ip, lpm_output_port, lpm_hit, rd_arp_result,
        output arp_mac_vld, next_hop_mac, output_port, arp_lookup_hit, lpm_lookup_hit
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after ptr (wrapping) wins, one-hot grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);
    logic [N-1:0] rot;
    logic [N-1:0] pick;

    // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        pick  = rot & (~rot + 1'b1);
        grant = N'(({pick, pick} << ptr) >> N);
        valid = |req;
    end

endmodule

// File: rtl/arp_lookup_arb.sv
// Shares one ip_arp lookup port among NUM_REQ requesters, one lookup in flight,
// with a result timeout and draining of orphaned results.
module arp_lookup_arb
    import arp_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_QUEUES = 8,
    parameter int TIMEOUT    = ARB_DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [32*NUM_REQ-1:0]         req_ip,
    input  logic [NUM_QUEUES*NUM_REQ-1:0] req_port,
    input  logic [NUM_REQ-1:0]            req_lpm_hit,
    output logic [NUM_REQ-1:0]            req_ack,
    arp_lookup_arb_if.master              arp,
    output logic [NUM_REQ-1:0]            rsp_vld,
    output logic [47:0]                   rsp_mac,
    output logic [NUM_QUEUES-1:0]         rsp_port,
    output logic                          rsp_arp_hit,
    output logic                          rsp_lpm_hit,
    output logic                          rsp_timeout,
    input  logic [NUM_REQ-1:0]            rsp_rd,
    output logic [7:0]                    stale_cnt
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    owner_q, owner_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            stale_q, stale_d;
    logic [31:0]           ip_q, ip_d;
    logic [NUM_QUEUES-1:0] port_q, port_d;
    logic                  hit_q, hit_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  lpm_vld_q, lpm_vld_d;
    logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
    logic [47:0]           rsp_mac_q, rsp_mac_d;
    logic [NUM_QUEUES-1:0] rsp_port_q, rsp_port_d;
    logic                  rsp_arp_hit_q, rsp_arp_hit_d;
    logic                  rsp_lpm_hit_q, rsp_lpm_hit_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  rd;

    logic [NUM_REQ-1:0]    gnt;
    logic                  gnt_vld;
    logic [31:0]           sel_ip;
    logic [NUM_QUEUES-1:0] sel_port;
    logic                  sel_hit;
    logic [PW-1:0]         owner_idx;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req   (req_vld),
        .ptr   (rr_ptr_q),
        .grant (gnt),
        .valid (gnt_vld)
    );

    always_comb begin
        sel_ip    = '0;
        sel_port  = '0;
        sel_hit   = 1'b0;
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_ip   = sel_ip | req_ip[i*32 +: 32];
                sel_port = sel_port | req_port[i*NUM_QUEUES +: NUM_QUEUES];
                sel_hit  = sel_hit | req_lpm_hit[i];
            end
            if (owner_q[i]) owner_idx = PW'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        stale_d       = stale_q;
        ip_d          = ip_q;
        port_d        = port_q;
        hit_d         = hit_q;
        ack_d         = '0;
        lpm_vld_d     = 1'b0;
        rsp_vld_d     = rsp_vld_q;
        rsp_mac_d     = rsp_mac_q;
        rsp_port_d    = rsp_port_q;
        rsp_arp_hit_d = rsp_arp_hit_q;
        rsp_lpm_hit_d = rsp_lpm_hit_q;
        rsp_timeout_d = rsp_timeout_q;
        rd            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A result with no lookup outstanding is an orphan: pop it before granting.
                if (arp.arp_mac_vld) begin
                    rd = 1'b1;
                    if (stale_q != 8'hFF) stale_d = stale_q + 8'd1;
                end else if (gnt_vld) begin
                    owner_d   = gnt;
                    ip_d      = sel_ip;
                    port_d    = sel_port;
                    hit_d     = sel_hit;
                    ack_d     = gnt;
                    lpm_vld_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // WAIT lasts at most TIMEOUT cycles; a result on the last one still wins.
                if (arp.arp_mac_vld) begin
                    rd            = 1'b1;
                    rsp_mac_d     = arp.next_hop_mac;
                    rsp_port_d    = arp.output_port;
                    rsp_arp_hit_d = arp.arp_lookup_hit;
                    rsp_lpm_hit_d = arp.lpm_lookup_hit;
                    rsp_timeout_d = 1'b0;
                    rsp_vld_d     = owner_q;
                    state_d       = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_mac_d     = '0;
                    rsp_port_d    = port_q;
                    rsp_arp_hit_d = 1'b0;
                    rsp_lpm_hit_d = hit_q;
                    rsp_timeout_d = 1'b1;
                    rsp_vld_d     = owner_q;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (|(rsp_rd & owner_q)) begin
                    rsp_vld_d = '0;
                    rr_ptr_d  = (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            stale_q       <= '0;
            ip_q          <= '0;
            port_q        <= '0;
            hit_q         <= 1'b0;
            ack_q         <= '0;
            lpm_vld_q     <= 1'b0;
            rsp_vld_q     <= '0;
            rsp_mac_q     <= '0;
            rsp_port_q    <= '0;
            rsp_arp_hit_q <= 1'b0;
            rsp_lpm_hit_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            stale_q       <= stale_d;
            ip_q          <= ip_d;
            port_q        <= port_d;
            hit_q         <= hit_d;
            ack_q         <= ack_d;
            lpm_vld_q     <= lpm_vld_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_mac_q     <= rsp_mac_d;
            rsp_port_q    <= rsp_port_d;
            rsp_arp_hit_q <= rsp_arp_hit_d;
            rsp_lpm_hit_q <= rsp_lpm_hit_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // The pop is combinational against the FIFO head, so hold it off while in reset.
    assign arp.rd_arp_result   = rd & reset_n;
    assign arp.lpm_vld         = lpm_vld_q;
    assign arp.next_hop_ip     = ip_q;
    assign arp.lpm_output_port = port_q;
    assign arp.lpm_hit         = hit_q;
    assign req_ack             = ack_q;
    assign rsp_vld             = rsp_vld_q;
    assign rsp_mac             = rsp_mac_q;
    assign rsp_port            = rsp_port_q;
    assign rsp_arp_hit         = rsp_arp_hit_q;
    assign rsp_lpm_hit         = rsp_lpm_hit_q;
    assign rsp_timeout         = rsp_timeout_q;
    assign stale_cnt           = stale_q;

endmodule

// File: tb/tb_arp_lookup_arb.sv
// Directed bench for arp_lookup_arb: arbitration order, latency, timeout, draining, reset.
module tb_arp_lookup_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_vld;
    logic [127:0] req_ip;
    logic [31:0] req_port;
    logic [3:0]  req_lpm_hit;
    logic [3:0]  req_ack;
    logic [3:0]  rsp_vld;
    logic [47:0] rsp_mac;
    logic [7:0]  rsp_port;
    logic        rsp_arp_hit, rsp_lpm_hit, rsp_timeout;
    logic [3:0]  rsp_rd;
    logic [7:0]  stale_cnt;

    int checks   = 0;
    int failures = 0;

    arp_lookup_arb_if #(.NUM_QUEUES(8)) arp ();

    arp_lookup_arb #(.NUM_REQ(4), .NUM_QUEUES(8), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_vld     (req_vld),
        .req_ip      (req_ip),
        .req_port    (req_port),
        .req_lpm_hit (req_lpm_hit),
        .req_ack     (req_ack),
        .arp         (arp),
        .rsp_vld     (rsp_vld),
        .rsp_mac     (rsp_mac),
        .rsp_port    (rsp_port),
        .rsp_arp_hit (rsp_arp_hit),
        .rsp_lpm_hit (rsp_lpm_hit),
        .rsp_timeout (rsp_timeout),
        .rsp_rd      (rsp_rd),
        .stale_cnt   (stale_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] ip, input logic [7:0] port,
                           input logic hit);
        req_ip[32*i +: 32]  = ip;
        req_port[8*i +: 8]  = port;
        req_lpm_hit[i]      = hit;
    endtask

    // One full lookup with all requesters held; expects requester idx to win.
    task automatic do_lookup(input int idx);
        logic [3:0] g;
        g = 4'b0001 << idx;
        tick();
        chk("rr_ack", req_ack, g);
        chk("rr_lpm_vld", arp.lpm_vld, 1);
        chk("rr_ip", arp.next_hop_ip, 32'h0A00_0100 + idx);
        tick();
        chk("rr_ack_one_cycle", req_ack, 0);
        arp.arp_mac_vld  = 1'b1;
        arp.next_hop_mac = 48'h0200_0000_0000 + 48'(idx);
        #1;
        chk("rr_pop", arp.rd_arp_result, 1);
        tick();
        arp.arp_mac_vld = 1'b0;
        chk("rr_rsp_vld", rsp_vld, g);
        chk("rr_rsp_mac", rsp_mac, 48'h0200_0000_0000 + 48'(idx));
        rsp_rd = g;
        tick();
        rsp_rd = '0;
    endtask

    initial begin
        logic early;
        reset_n     = 1'b0;
        req_vld     = '0;
        req_ip      = '0;
        req_port    = '0;
        req_lpm_hit = '0;
        rsp_rd      = '0;
        arp.arp_mac_vld    = 1'b0;
        arp.next_hop_mac   = '0;
        arp.output_port    = '0;
        arp.arp_lookup_hit = 1'b0;
        arp.lpm_lookup_hit = 1'b0;

        // Reset state, including a result present while reset is held.
        tick();
        tick();
        arp.arp_mac_vld = 1'b1;
        #1;
        chk("rst_ack", req_ack, 0);
        chk("rst_lpm_vld", arp.lpm_vld, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_stale", stale_cnt, 0);
        chk("rst_no_pop", arp.rd_arp_result, 0);
        arp.arp_mac_vld = 1'b0;
        tick();
        reset_n = 1'b1;

        // All four held, immediate rsp_rd: grants 0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_req(i, 32'h0A00_0100 + i, 8'h10 + 8'(i), 1'b0);
        req_vld = 4'b1111;
        do_lookup(0);
        do_lookup(1);
        do_lookup(2);
        do_lookup(3);
        do_lookup(0);
        req_vld = '0;

        // Single requester 0, result after 3 cycles, owner delays rsp_rd.
        set_req(0, 32'h0A00_0001, 8'h04, 1'b1);
        req_vld = 4'b0001;
        tick();
        chk("s_ack", req_ack, 4'b0001);
        chk("s_lpm_vld", arp.lpm_vld, 1);
        chk("s_ip", arp.next_hop_ip, 32'h0A00_0001);
        chk("s_port", arp.lpm_output_port, 8'h04);
        chk("s_hit", arp.lpm_hit, 1);
        req_vld = '0;
        tick();
        chk("s_ack_drop", req_ack, 0);
        tick();
        tick();
        arp.arp_mac_vld    = 1'b1;
        arp.next_hop_mac   = 48'h0011_2233_4455;
        arp.output_port    = 8'h04;
        arp.arp_lookup_hit = 1'b1;
        arp.lpm_lookup_hit = 1'b1;
        #1;
        chk("s_pop_same_cycle", arp.rd_arp_result, 1);
        chk("s_rsp_not_yet", rsp_vld, 0);
        tick();
        arp.arp_mac_vld = 1'b0;
        chk("s_rsp_vld", rsp_vld, 4'b0001);
        chk("s_rsp_mac", rsp_mac, 48'h0011_2233_4455);
        chk("s_rsp_port", rsp_port, 8'h04);
        chk("s_rsp_arp_hit", rsp_arp_hit, 1);
        chk("s_rsp_lpm_hit", rsp_lpm_hit, 1);
        chk("s_rsp_timeout", rsp_timeout, 0);
        // Non-owner rsp_rd and a result during RESP are both ignored.
        arp.arp_mac_vld = 1'b1;
        rsp_rd = 4'b0010;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("d_rsp_vld", rsp_vld, 4'b0001);
            chk("d_rsp_mac", rsp_mac, 48'h0011_2233_4455);
            chk("d_no_lpm_vld", arp.lpm_vld, 0);
            chk("d_no_pop", arp.rd_arp_result, 0);
            tick();
        end
        arp.arp_mac_vld = 1'b0;
        rsp_rd = 4'b0001;
        tick();
        rsp_rd = '0;
        chk("d_rsp_done", rsp_vld, 0);

        // Orphan result in IDLE while requester 1 waits: drain first, grant next.
        set_req(1, 32'hC0A8_0101, 8'h20, 1'b1);
        req_vld = 4'b0010;
        arp.arp_mac_vld = 1'b1;
        #1;
        chk("o_pop", arp.rd_arp_result, 1);
        tick();
        arp.arp_mac_vld = 1'b0;
        chk("o_no_ack", req_ack, 0);
        chk("o_stale", stale_cnt, 1);
        tick();
        chk("o_ack_next", req_ack, 4'b0010);
        chk("o_ip", arp.next_hop_ip, 32'hC0A8_0101);
        req_vld = '0;

        // No result: timeout response after 64 WAIT cycles.
        tick();
        early = 1'b0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (rsp_vld !== 4'b0000) early = 1'b1;
        end
        chk("t_not_early", early, 0);
        tick();
        chk("t_rsp_vld", rsp_vld, 4'b0010);
        chk("t_timeout", rsp_timeout, 1);
        chk("t_mac", rsp_mac, 0);
        chk("t_arp_hit", rsp_arp_hit, 0);
        chk("t_lpm_hit", rsp_lpm_hit, 1);
        chk("t_port", rsp_port, 8'h20);
        rsp_rd = 4'b0010;
        tick();
        rsp_rd = '0;
        arp.arp_mac_vld = 1'b1;
        #1;
        chk("t_late_pop", arp.rd_arp_result, 1);
        tick();
        arp.arp_mac_vld = 1'b0;
        chk("t_late_stale", stale_cnt, 2);

        // Result on the final WAIT cycle beats the timeout.
        set_req(2, 32'h0A0A_0A0A, 8'h80, 1'b0);
        req_vld = 4'b0100;
        tick();
        chk("b_ack", req_ack, 4'b0100);
        req_vld = '0;
        tick();
        for (int i = 0; i < 63; i++) tick();
        arp.arp_mac_vld    = 1'b1;
        arp.next_hop_mac   = 48'hAABB_CCDD_EEFF;
        arp.output_port    = 8'h81;
        arp.arp_lookup_hit = 1'b1;
        arp.lpm_lookup_hit = 1'b1;
        #1;
        chk("b_pop", arp.rd_arp_result, 1);
        tick();
        arp.arp_mac_vld = 1'b0;
        chk("b_rsp_vld", rsp_vld, 4'b0100);
        chk("b_timeout", rsp_timeout, 0);
        chk("b_mac", rsp_mac, 48'hAABB_CCDD_EEFF);
        chk("b_port", rsp_port, 8'h81);
        rsp_rd = 4'b0100;
        tick();
        rsp_rd = '0;

        // Reset during WAIT: outputs clear at once, the late result drains as stale.
        set_req(3, 32'h0A00_0303, 8'h08, 1'b0);
        req_vld = 4'b1000;
        tick();
        chk("r_ack", req_ack, 4'b1000);
        req_vld = '0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("r_ack_clr", req_ack, 0);
        chk("r_lpm_clr", arp.lpm_vld, 0);
        chk("r_rsp_clr", rsp_vld, 0);
        chk("r_stale_clr", stale_cnt, 0);
        arp.arp_mac_vld = 1'b1;
        #1;
        chk("r_no_pop_in_reset", arp.rd_arp_result, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("r_drain_pop", arp.rd_arp_result, 1);
        tick();
        arp.arp_mac_vld = 1'b0;
        chk("r_stale", stale_cnt, 1);
        chk("r_no_rsp", rsp_vld, 0);
        chk("r_no_ack", req_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arp_lookup_arb.md
ARP_LOOKUP_ARB -- requirements
Module: arp_lookup_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of lookup requesters sharing one ip_arp lookup port.
REQ-002 SHALL have parameter NUM_QUEUES, default 8, output-port bitmap width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for a lookup result.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_vld  in  NUM_REQ  per-requester lookup request, held until req_ack.
REQ-007 SHALL have port req_ip  in  32*NUM_REQ  next-hop IP, slice i for requester i.
REQ-008 SHALL have port req_port  in  NUM_QUEUES*NUM_REQ  LPM output port, slice i.
REQ-009 SHALL have port req_lpm_hit  in  NUM_REQ  LPM hit flag, bit i.
REQ-010 SHALL have port req_ack  out  NUM_REQ  one-cycle grant/capture pulse.
REQ-011 SHALL have ports lpm_vld, next_hop_ip, lpm_output_port, lpm_hit  out  1/32/NUM_QUEUES/1  lookup issue to ip_arp.
REQ-012 SHALL have ports arp_mac_vld, next_hop_mac, output_port, arp_lookup_hit, lpm_lookup_hit  in  1/48/NUM_QUEUES/1/1  ip_arp result FIFO head.
REQ-013 SHALL have port rd_arp_result  out  1  pops ip_arp result FIFO.
REQ-014 SHALL have ports rsp_vld  out  NUM_REQ, rsp_mac  out  48, rsp_port  out  NUM_QUEUES, rsp_arp_hit  out  1, rsp_lpm_hit  out  1, rsp_timeout  out  1  response to owner.
REQ-015 SHALL have port rsp_rd  in  NUM_REQ  owner accepts response.
REQ-016 SHALL have port stale_cnt  out  8  saturating count of drained orphan results.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; one lookup in flight at a time.
REQ-018 IDLE: if arp_mac_vld, SHALL assert rd_arp_result, increment stale_cnt (saturate at 255), grant nothing that cycle.
REQ-019 IDLE with no arp_mac_vld and any req_vld: SHALL select winner round-robin starting at rr_ptr, capture its IP/port/lpm_hit, record owner, go ISSUE.
REQ-020 ISSUE (exactly 1 cycle): SHALL assert lpm_vld with captured fields and req_ack[owner]; clear timeout counter; go WAIT.
REQ-021 WAIT: on arp_mac_vld SHALL assert rd_arp_result combinationally same cycle, capture mac/port/arp_hit/lpm_hit, rsp_timeout=0, go RESP.
REQ-022 WAIT: counter increments each cycle; when it reaches TIMEOUT-1 without arp_mac_vld SHALL go RESP with rsp_mac=0, rsp_arp_hit=0, rsp_lpm_hit=captured value, rsp_port=captured port, rsp_timeout=1.
REQ-023 arp_mac_vld on the timeout cycle SHALL win (normal result, no timeout).
REQ-024 RESP: rsp_vld[owner]=1, other bits 0, response fields stable; on rsp_rd[owner] go IDLE, rr_ptr=(owner+1) mod NUM_REQ.
REQ-025 rsp_rd bits for non-owners and arp_mac_vld outside WAIT/IDLE SHALL be ignored (no pop).
REQ-026 Latency: req_vld seen in IDLE at cycle t -> req_ack/lpm_vld at t+1; result in WAIT at cycle u -> rsp_vld at u+1.
REQ-027 Late result after timeout SHALL be drained in IDLE per REQ-018.
REQ-028 Back-to-back: requester holding req_vld after ack SHALL be re-arbitrated normally; rr_ptr ensures no requester waits more than NUM_REQ grants.

Reset
REQ-029 On reset_n low (async): state=IDLE, rr_ptr=0, counter=0, stale_cnt=0, all outputs 0 (req_ack, lpm_vld, rd_arp_result, rsp_* all 0).
REQ-030 Reset mid-lookup SHALL abandon it; its result later drains as stale.

Structure
REQ-031 Package arp_arb_pkg SHALL hold FSM state encoding and default TIMEOUT.
REQ-032 Round-robin selection SHALL be sub-module rr_arbiter (req, ptr -> one-hot grant, valid).

Verification
REQ-033 Single req: req_vld=0001, ip=0A000001; result hit, mac=001122334455 after 3 cycles -> req_ack[0] at t+1, rsp_vld=0001 at u+1, rsp_mac=001122334455, rsp_timeout=0.
REQ-034 All four req_vld=1111 held, rsp_rd immediate -> grant order 0,1,2,3,0; each ack one cycle.
REQ-035 No result, TIMEOUT=64 -> rsp_vld 64 cycles after ISSUE, rsp_timeout=1, rsp_mac=0; late result then drained, stale_cnt=1.
REQ-036 arp_mac_vld in IDLE while req_vld=0010 -> rd_arp_result=1, no ack that cycle, grant next cycle.
REQ-037 reset_n low during WAIT -> outputs 0 immediately; after release, pending result drained, stale_cnt=1.
REQ-038 Owner delays rsp_rd 10 cycles -> rsp fields stable, no new lpm_vld during delay.
